// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipeline_hazard_ctrl.
//   master : datapath side; drives the IF/ID and EX status fields and samples
//            the pipeline controls, FSM state and stall counter.
//   slave  : controller side; the reverse directions.
// Fields:
//   id_rs1/id_rs2/id_valid          source registers and valid flag of the IF/ID instruction
//   ex_mem_read/ex_reg_write/ex_rd  load/writeback flags and destination of the EX instruction
//   branch_taken                    EX resolved a taken branch/jump this cycle
//   mc_start/mc_cycles              multi-cycle EX op issued, total occupancy in cycles
//   pc_write_en/if_id_write_en/if_id_flush/id_ex_bubble   pipeline controls
//   hz_state/stall_cycles           current FSM state, saturating stall-cycle count
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_valid;
    logic        ex_mem_read;
    logic        ex_reg_write;
    logic [4:0]  ex_rd;
    logic        branch_taken;
    logic        mc_start;
    logic [3:0]  mc_cycles;
    logic        pc_write_en;
    logic        if_id_write_en;
    logic        if_id_flush;
    logic        id_ex_bubble;
    logic [1:0]  hz_state;
    logic [15:0] stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_valid, ex_mem_read, ex_reg_write, ex_rd,
               branch_taken, mc_start, mc_cycles,
        input  pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               hz_state, stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_valid, ex_mem_read, ex_reg_write, ex_rd,
               branch_taken, mc_start, mc_cycles,
        output pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
               hz_state, stall_cycles
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and
// multi-cycle EX freezes, with a saturating count of stalled cycles.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : pipeline_hazard_ctrl_if.slave (see interface for field list)
// States: RUN=00, FLUSH=01, MC_WAIT=10; 11 falls back to RUN.
module pipeline_hazard_ctrl (
    input  logic                   clk,
    input  logic                   rst,
    pipeline_hazard_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        StRun    = 2'b00,
        StFlush  = 2'b01,
        StMcWait = 2'b10,
        StBad    = 2'b11
    } state_e;

    state_e      r_state;
    logic [3:0]  r_cnt;
    logic [15:0] r_stall;

    logic w_load_use;
    logic w_mc_go;
    logic w_pc_write_en;
    logic w_if_id_write_en;
    logic w_if_id_flush;
    logic w_id_ex_bubble;

    always_comb begin
        w_load_use = bus.ex_mem_read & bus.ex_reg_write & (bus.ex_rd != 5'd0) & bus.id_valid &
                     ((bus.ex_rd == bus.id_rs1) | (bus.ex_rd == bus.id_rs2));
        w_mc_go    = bus.mc_start & (bus.mc_cycles != 4'd0);
    end

    // Controls are combinational; rst is folded in so they read as the
    // free-running defaults for as long as reset is held.
    always_comb begin
        w_pc_write_en    = 1'b1;
        w_if_id_write_en = 1'b1;
        w_if_id_flush    = 1'b0;
        w_id_ex_bubble   = 1'b0;
        if (!rst) begin
            unique case (r_state)
                StRun: begin
                    if (bus.branch_taken) begin
                        w_if_id_flush  = 1'b1;
                        w_id_ex_bubble = 1'b1;
                    end else if (w_mc_go || w_load_use) begin
                        w_pc_write_en    = 1'b0;
                        w_if_id_write_en = 1'b0;
                        w_id_ex_bubble   = 1'b1;
                    end
                end
                StFlush: begin
                    w_if_id_flush = 1'b1;
                end
                StMcWait: begin
                    w_pc_write_en    = 1'b0;
                    w_if_id_write_en = 1'b0;
                    w_id_ex_bubble   = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StRun;
            r_cnt   <= 4'd0;
            r_stall <= 16'd0;
        end else begin
            if (!w_pc_write_en && (r_stall != 16'hFFFF)) begin
                r_stall <= r_stall + 16'd1;
            end
            unique case (r_state)
                StRun: begin
                    if (bus.branch_taken) begin
                        r_state <= StFlush;
                    end else if (w_mc_go && (bus.mc_cycles != 4'd1)) begin
                        // The RUN issue cycle is the first of N frozen cycles, and
                        // MC_WAIT runs cnt+1 cycles, so cnt starts at N-2.
                        r_state <= StMcWait;
                        r_cnt   <= bus.mc_cycles - 4'd2;
                    end
                end
                StFlush: begin
                    r_state <= StRun;
                end
                StMcWait: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= StRun;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= StRun;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    assign bus.pc_write_en    = w_pc_write_en;
    assign bus.if_id_write_en = w_if_id_write_en;
    assign bus.if_id_flush    = w_if_id_flush;
    assign bus.id_ex_bubble   = w_id_ex_bubble;
    assign bus.hz_state       = r_state;
    assign bus.stall_cycles   = r_stall;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic against a
// cycle-count reference model.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       valid;
        logic       mr;
        logic       rw;
        logic       br;
        logic       mcs;
        logic [3:0] mcn;
        logic [3:0] exp_out;   // {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble}
        logic [1:0] exp_state; // hz_state after one edge
    } vec_t;

    function automatic vec_t mk(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic [4:0] rd, input logic valid, input logic mr,
                                input logic rw, input logic br, input logic mcs,
                                input logic [3:0] mcn, input logic [3:0] eo,
                                input logic [1:0] es);
        vec_t v;
        v.name = name; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.valid = valid;
        v.mr = mr; v.rw = rw; v.br = br; v.mcs = mcs; v.mcn = mcn;
        v.exp_out = eo; v.exp_state = es;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.pc_write_en, bus.if_id_write_en, bus.if_id_flush, bus.id_ex_bubble};
    endfunction

    task automatic idle_inputs();
        bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_valid = 1'b0;
        bus.ex_mem_read = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = 5'd0;
        bus.branch_taken = 1'b0; bus.mc_start = 1'b0; bus.mc_cycles = 4'd0;
    endtask

    task automatic set_load_use();
        bus.ex_mem_read = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd7;
        bus.id_rs1 = 5'd7; bus.id_valid = 1'b1;
    endtask

    // Leaves time at posedge+1 with reset released.
    task automatic apply_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    task automatic mc_run(input logic [3:0] n, input int exp_low);
        int lows = 0;
        apply_reset();
        bus.mc_start  = 1'b1;
        bus.mc_cycles = n;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (!bus.pc_write_en) lows++;
            edge1();
            bus.mc_start = 1'b0;
        end
        chk($sformatf("mc%0d_freeze_len", n), lows, exp_low);
        chk($sformatf("mc%0d_stall_cnt", n), bus.stall_cycles, exp_low);
        chk($sformatf("mc%0d_end_state", n), bus.hz_state, 2'b00);
    endtask

    // Reference model: remaining freeze cycles and pending flush, not FSM states.
    bit m_flush_pending;
    int m_freeze_left;
    int m_stall;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        vecs[0]  = mk("idle",          0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100, 2'b00);
        vecs[1]  = mk("lu_rs2",        1, 5, 5, 1, 1, 1, 0, 0, 0, 4'b0001, 2'b00);
        vecs[2]  = mk("lu_rd0",        0, 5, 0, 1, 1, 1, 0, 0, 0, 4'b1100, 2'b00);
        vecs[3]  = mk("lu_invalid",    9, 2, 9, 0, 1, 1, 0, 0, 0, 4'b1100, 2'b00);
        vecs[4]  = mk("lu_no_memrd",   9, 2, 9, 1, 0, 1, 0, 0, 0, 4'b1100, 2'b00);
        vecs[5]  = mk("branch",        0, 0, 0, 0, 0, 0, 1, 0, 0, 4'b1111, 2'b01);
        vecs[6]  = mk("mc4",           0, 0, 0, 0, 0, 0, 0, 1, 4, 4'b0001, 2'b10);
        vecs[7]  = mk("mc1",           0, 0, 0, 0, 0, 0, 0, 1, 1, 4'b0001, 2'b00);
        vecs[8]  = mk("mc0",           0, 0, 0, 0, 0, 0, 0, 1, 0, 4'b1100, 2'b00);
        vecs[9]  = mk("prio_all",      3, 3, 3, 1, 1, 1, 1, 1, 3, 4'b1111, 2'b01);
        vecs[10] = mk("mc2_over_lu",   3, 4, 3, 1, 1, 1, 0, 1, 2, 4'b0001, 2'b10);

        idle_inputs();
        apply_reset();
        #2;
        chk("reset_state", bus.hz_state, 2'b00);
        chk("reset_stall", bus.stall_cycles, 16'd0);
        chk("reset_outs", outs(), 4'b1100);

        foreach (vecs[i]) begin
            apply_reset();
            bus.id_rs1 = vecs[i].rs1; bus.id_rs2 = vecs[i].rs2; bus.ex_rd = vecs[i].rd;
            bus.id_valid = vecs[i].valid; bus.ex_mem_read = vecs[i].mr;
            bus.ex_reg_write = vecs[i].rw; bus.branch_taken = vecs[i].br;
            bus.mc_start = vecs[i].mcs; bus.mc_cycles = vecs[i].mcn;
            #2;
            chk({vecs[i].name, "_outs"}, outs(), vecs[i].exp_out);
            edge1();
            chk({vecs[i].name, "_next"}, bus.hz_state, vecs[i].exp_state);
            idle_inputs();
        end

        // Branch: flush for exactly RUN + FLUSH; inputs during FLUSH are ignored.
        begin
            int fl = 0;
            int lows = 0;
            apply_reset();
            bus.branch_taken = 1'b1;
            for (int k = 0; k < 6; k++) begin
                #2;
                if (bus.if_id_flush) fl++;
                if (!bus.pc_write_en) lows++;
                if (k == 1) chk("flush_state", bus.hz_state, 2'b01);
                if (k == 1) chk("flush_no_bubble", bus.id_ex_bubble, 1'b0);
                edge1();
                bus.branch_taken = 1'b0;
                bus.mc_start     = (k == 0);
                bus.mc_cycles    = 4'd3;
            end
            chk("branch_flush_len", fl, 2);
            chk("branch_no_stall", lows, 0);
            chk("branch_end_state", bus.hz_state, 2'b00);
        end

        mc_run(4'd4, 4);
        mc_run(4'd1, 1);
        mc_run(4'd0, 0);
        mc_run(4'd2, 2);
        mc_run(4'd15, 15);

        // Priority: branch wins, no stall cycles accrue.
        apply_reset();
        bus.branch_taken = 1'b1; bus.mc_start = 1'b1; bus.mc_cycles = 4'd3;
        set_load_use();
        #2;
        chk("prio_outs", outs(), 4'b1111);
        edge1();
        idle_inputs();
        repeat (4) edge1();
        chk("prio_stall", bus.stall_cycles, 16'd0);
        chk("prio_state", bus.hz_state, 2'b00);

        // Reset during the 5th frozen cycle of a 15-cycle op, with load-use pending.
        apply_reset();
        bus.mc_start = 1'b1; bus.mc_cycles = 4'd15;
        edge1();
        bus.mc_start = 1'b0;
        set_load_use();
        repeat (3) edge1();
        #2;
        chk("rstmc_frozen", bus.pc_write_en, 1'b0);
        chk("rstmc_pre_state", bus.hz_state, 2'b10);
        rst = 1'b1;
        #1;
        chk("rstmc_outs", outs(), 4'b1100);
        chk("rstmc_state", bus.hz_state, 2'b00);
        chk("rstmc_stall", bus.stall_cycles, 16'd0);
        chk("rstmc_cnt", dut.r_cnt, 4'd0);
        edge1();
        chk("rstmc_held_outs", outs(), 4'b1100);
        rst = 1'b0;
        bus.id_valid = 1'b0;
        #2;
        chk("rstmc_release_state", bus.hz_state, 2'b00);
        idle_inputs();
        edge1();

        // Randomized traffic vs model.
        apply_reset();
        m_flush_pending = 0; m_freeze_left = 0; m_stall = 0;
        for (int i = 0; i < 2000; i++) begin
            bit         lu;
            logic [3:0] eo;
            logic [1:0] es;
            bus.ex_rd        = 5'($urandom_range(0, 3));
            bus.id_rs1       = 5'($urandom_range(0, 3));
            bus.id_rs2       = 5'($urandom_range(0, 3));
            bus.id_valid     = 1'($urandom_range(0, 3) != 0);
            bus.ex_mem_read  = 1'($urandom_range(0, 1));
            bus.ex_reg_write = 1'($urandom_range(0, 3) != 0);
            bus.branch_taken = ($urandom_range(0, 7) == 0);
            bus.mc_start     = ($urandom_range(0, 5) == 0);
            bus.mc_cycles    = 4'($urandom_range(0, 15));
            lu = bus.ex_mem_read && bus.ex_reg_write && bus.ex_rd != 0 && bus.id_valid &&
                 (bus.ex_rd == bus.id_rs1 || bus.ex_rd == bus.id_rs2);
            if (m_flush_pending) begin
                eo = 4'b1110; es = 2'b01;
            end else if (m_freeze_left > 0) begin
                eo = 4'b0001; es = 2'b10;
            end else begin
                es = 2'b00;
                if (bus.branch_taken) eo = 4'b1111;
                else if ((bus.mc_start && bus.mc_cycles != 0) || lu) eo = 4'b0001;
                else eo = 4'b1100;
            end
            #2;
            chk("rand_outs", outs(), eo);
            chk("rand_state", bus.hz_state, es);
            chk("rand_stall", bus.stall_cycles, m_stall);
            if (bus.if_id_flush && !bus.if_id_write_en) chk("rand_flush_vs_hold", 1, 0);
            if (m_flush_pending) m_flush_pending = 0;
            else if (m_freeze_left > 0) m_freeze_left--;
            else if (bus.branch_taken) m_flush_pending = 1;
            else if (bus.mc_start && bus.mc_cycles != 0) m_freeze_left = int'(bus.mc_cycles) - 1;
            if (eo[3] == 1'b0 && m_stall < 65535) m_stall++;
            edge1();
        end
        idle_inputs();

        // Saturation via continuous load-use stalls.
        apply_reset();
        set_load_use();
        repeat (65540) @(posedge clk);
        #3;
        chk("sat_value", bus.stall_cycles, 16'hFFFF);
        chk("sat_still_stalling", bus.pc_write_en, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        chk("sat_hold", bus.stall_cycles, 16'hFFFF);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
